uart_tx_arbiter: RTL and testbench

Shares the byte-wide UART transmit FIFO between two message sources in the ICAP controller: requester 0 (ICAP readback words) and requester 1 (status/ack messages). It accepts a 1–4 byte message from one requester at a time using round-robin arbitration, and serializes the message MSB-first into the FIFO write port. A credit counter mirrors FIFO occupancy, because the FIFO exposes no full flag, so the FIFO never overflows.

---
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serializes 1-4 byte messages from two requesters
// MSB-first into a byte FIFO, with a credit counter that mirrors FIFO occupancy.
module uart_tx_arbiter #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CW         = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [31:0]   req0_data,
    input  logic [1:0]    req0_len,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [31:0]   req1_data,
    input  logic [1:0]    req1_len,
    output logic          req1_ready,
    output logic          fifo_en,
    output logic [7:0]    fifo_data,
    input  logic          fifo_pop,
    output logic          busy,
    output logic          grant,
    output logic [CW-1:0] credits,
    output logic          overflow_err
);

    localparam logic [CW-1:0] CRED_MAX  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CRED_ONE  = CW'(1);
    localparam logic [CW-1:0] CRED_ZERO = CW'(0);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   shift;
    logic [31:0]   shift_nxt;
    logic [1:0]    bytes_left;
    logic [1:0]    bytes_left_nxt;
    logic          last_grant;
    logic          last_grant_nxt;
    logic          grant_nxt;
    logic          req0_ready_nxt;
    logic          req1_ready_nxt;
    logic          fifo_en_nxt;
    logic [7:0]    fifo_data_nxt;
    logic          busy_nxt;
    logic [CW-1:0] credits_nxt;
    logic          overflow_nxt;
    logic          issue;
    logic          pick1;

    // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
    assign pick1 = req1_valid && (!req0_valid || !last_grant);

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift;
        bytes_left_nxt = bytes_left;
        last_grant_nxt = last_grant;
        grant_nxt      = grant;
        req0_ready_nxt = 1'b0;
        req1_ready_nxt = 1'b0;
        fifo_en_nxt    = 1'b0;
        fifo_data_nxt  = fifo_data;
        issue          = 1'b0;

        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_nxt      = SEND;
                    grant_nxt      = pick1;
                    last_grant_nxt = pick1;
                    shift_nxt      = pick1 ? req1_data : req0_data;
                    bytes_left_nxt = pick1 ? req1_len : req0_len;
                    req0_ready_nxt = !pick1;
                    req1_ready_nxt = pick1;
                end
            end
            SEND: begin
                // Issue is gated on the registered credit count; zero credits stalls.
                if (credits != CRED_ZERO) begin
                    issue         = 1'b1;
                    fifo_en_nxt   = 1'b1;
                    fifo_data_nxt = shift[31:24];
                    shift_nxt     = {shift[23:0], 8'h00};
                    if (bytes_left == 2'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        bytes_left_nxt = bytes_left - 2'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == SEND);
    end

    // Credit tracking: a pop while already full saturates and raises the sticky error.
    always_comb begin
        credits_nxt  = credits;
        overflow_nxt = overflow_err;
        if (issue && !fifo_pop) begin
            credits_nxt = credits - CRED_ONE;
        end else if (!issue && fifo_pop) begin
            if (credits == CRED_MAX) begin
                overflow_nxt = 1'b1;
            end else begin
                credits_nxt = credits + CRED_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            shift        <= 32'h0;
            bytes_left   <= 2'd0;
            last_grant   <= 1'b1;
            grant        <= 1'b0;
            req0_ready   <= 1'b0;
            req1_ready   <= 1'b0;
            fifo_en      <= 1'b0;
            fifo_data    <= 8'h00;
            busy         <= 1'b0;
            credits      <= CRED_MAX;
            overflow_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            shift        <= shift_nxt;
            bytes_left   <= bytes_left_nxt;
            last_grant   <= last_grant_nxt;
            grant        <= grant_nxt;
            req0_ready   <= req0_ready_nxt;
            req1_ready   <= req1_ready_nxt;
            fifo_en      <= fifo_en_nxt;
            fifo_data    <= fifo_data_nxt;
            busy         <= busy_nxt;
            credits      <= credits_nxt;
            overflow_err <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic [1:0]  req0_len;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic [1:0]  req1_len;
    logic        req1_ready;
    logic        fifo_en;
    logic [7:0]  fifo_data;
    logic        fifo_pop;
    logic        busy;
    logic        grant;
    logic [3:0]  credits;
    logic        overflow_err;

    int tests;
    int fails;
    logic [7:0] wr_bytes[$];

    uart_tx_arbiter #(.FIFO_DEPTH(8), .CW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_len    (req0_len),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_len    (req1_len),
        .req1_ready  (req1_ready),
        .fifo_en     (fifo_en),
        .fifo_data   (fifo_data),
        .fifo_pop    (fifo_pop),
        .busy        (busy),
        .grant       (grant),
        .credits     (credits),
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte log of everything written into the FIFO, sampled mid-cycle.
    always @(negedge clk) begin
        if (fifo_en) wr_bytes.push_back(fifo_data);
    end

    typedef struct {
        logic        rst;
        logic        v0;
        logic [31:0] d0;
        logic [1:0]  l0;
        logic        v1;
        logic [31:0] d1;
        logic [1:0]  l1;
        logic        pop;
        logic [17:0] exp;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    // Expected outputs packed as {ready0, ready1, en, data, busy, grant, credits, ovf}.
    function automatic logic [17:0] ex(input logic r0, input logic r1, input logic en,
                                       input logic [7:0] d, input logic b, input logic g,
                                       input logic [3:0] c, input logic o);
        return {r0, r1, en, d, b, g, c, o};
    endfunction

    function automatic vec_t mk(input logic rst, input logic v0, input logic [31:0] d0,
                                input logic [1:0] l0, input logic v1, input logic [31:0] d1,
                                input logic [1:0] l1, input logic pop, input logic [17:0] e);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1; v.pop = pop; v.exp = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_msg(input logic who, input logic [31:0] d, input logic [1:0] l);
        logic got;
        got = 1'b0;
        if (!who) begin
            req0_valid = 1'b1; req0_data = d; req0_len = l;
        end else begin
            req1_valid = 1'b1; req1_data = d; req1_len = l;
        end
        for (int n = 0; n < 50 && !got; n++) begin
            tick();
            if ((!who && req0_ready) || (who && req1_ready)) got = 1'b1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("send_ack", 32'(got), 32'd1);
    endtask

    initial begin
        logic [17:0] act;
        tests = 0;
        fails = 0;
        reset = 1'b0; fifo_pop = 1'b0;
        req0_valid = 1'b0; req0_data = 32'h0; req0_len = 2'd0;
        req1_valid = 1'b0; req1_data = 32'h0; req1_len = 2'd0;

        // Reset, single 4-byte message, credit return, then tie arbitration.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 8'h00, 0, 0, 8, 0));
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 8'h00, 0, 0, 8, 0));
        vecs[2]  = mk(1, 1, 32'hA1B2C3D4, 3, 0, 0, 0, 0, ex(1, 0, 0, 8'h00, 1, 0, 8, 0));
        vecs[3]  = mk(1, 1, 32'hA1B2C3D4, 3, 0, 0, 0, 0, ex(0, 0, 1, 8'hA1, 1, 0, 7, 0));
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 1, 8'hB2, 1, 0, 6, 0));
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 1, 8'hC3, 1, 0, 5, 0));
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 1, 8'hD4, 0, 0, 4, 0));
        vecs[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 8'hD4, 0, 0, 4, 0));
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 8'hD4, 0, 0, 5, 0));
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 8'hD4, 0, 0, 6, 0));
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 8'hD4, 0, 0, 7, 0));
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 8'hD4, 0, 0, 8, 0));
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 8'h00, 0, 0, 8, 0));
        vecs[13] = mk(1, 1, 32'h11AABBCC, 0, 1, 32'h22DDEEFF, 0, 0, ex(1, 0, 0, 8'h00, 1, 0, 8, 0));
        vecs[14] = mk(1, 1, 32'h11AABBCC, 0, 1, 32'h22DDEEFF, 0, 0, ex(0, 0, 1, 8'h11, 0, 0, 7, 0));
        vecs[15] = mk(1, 1, 32'h11AABBCC, 0, 1, 32'h22DDEEFF, 0, 0, ex(0, 1, 0, 8'h11, 1, 1, 7, 0));
        vecs[16] = mk(1, 1, 32'h11AABBCC, 0, 1, 32'h22DDEEFF, 0, 0, ex(0, 0, 1, 8'h22, 0, 1, 6, 0));
        vecs[17] = mk(1, 1, 32'h11AABBCC, 0, 1, 32'h22DDEEFF, 0, 0, ex(1, 0, 0, 8'h22, 1, 0, 6, 0));
        vecs[18] = mk(1, 1, 32'h11AABBCC, 0, 1, 32'h22DDEEFF, 0, 0, ex(0, 0, 1, 8'h11, 0, 0, 5, 0));
        vecs[19] = mk(1, 1, 32'h11AABBCC, 0, 1, 32'h22DDEEFF, 0, 0, ex(0, 1, 0, 8'h11, 1, 1, 5, 0));
        vecs[20] = mk(1, 1, 32'h11AABBCC, 0, 1, 32'h22DDEEFF, 0, 0, ex(0, 0, 1, 8'h22, 0, 1, 4, 0));
        vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 8'h22, 0, 1, 4, 0));

        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst;
            req0_valid = vecs[i].v0; req0_data = vecs[i].d0; req0_len = vecs[i].l0;
            req1_valid = vecs[i].v1; req1_data = vecs[i].d1; req1_len = vecs[i].l1;
            fifo_pop = vecs[i].pop;
            tick();
            act = {req0_ready, req1_ready, fifo_en, fifo_data, busy, grant, credits, overflow_err};
            chk($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
        end
        req0_valid = 1'b0; req1_valid = 1'b0; fifo_pop = 1'b0;

        // Credit stall: 9 bytes against 8 credits with no pops.
        reset = 1'b0; tick(); reset = 1'b1;
        wr_bytes.delete();
        send_msg(1'b0, 32'h01020304, 2'd3);
        send_msg(1'b0, 32'h05060708, 2'd3);
        send_msg(1'b1, 32'h09FFFFFF, 2'd0);
        repeat (4) tick();
        chk("stall_count", 32'(wr_bytes.size()), 32'd8);
        chk("stall_en", 32'(fifo_en), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_credits", 32'(credits), 32'd0);
        fifo_pop = 1'b1; tick(); fifo_pop = 1'b0;
        chk("pop_credits", 32'(credits), 32'd1);
        chk("pop_no_issue", 32'(fifo_en), 32'd0);
        tick();
        chk("ninth_en", 32'(fifo_en), 32'd1);
        chk("ninth_data", 32'(fifo_data), 32'h09);
        chk("ninth_credits", 32'(credits), 32'd0);
        tick();
        chk("stall_total", 32'(wr_bytes.size()), 32'd9);
        for (int i = 0; i < 9 && i < wr_bytes.size(); i++)
            chk($sformatf("stall_byte%0d", i), 32'(wr_bytes[i]), 32'(i + 1));

        // Simultaneous pop and issue with one credit left.
        fifo_pop = 1'b1; tick(); fifo_pop = 1'b0;
        chk("sim_pre_credits", 32'(credits), 32'd1);
        req0_valid = 1'b1; req0_data = 32'hAABB0000; req0_len = 2'd1;
        tick();
        chk("sim_ready", 32'(req0_ready), 32'd1);
        req0_valid = 1'b0; fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        chk("sim_en", 32'(fifo_en), 32'd1);
        chk("sim_data", 32'(fifo_data), 32'hAA);
        chk("sim_credits", 32'(credits), 32'd1);
        tick();
        chk("sim_data2", 32'(fifo_data), 32'hBB);
        chk("sim_credits2", 32'(credits), 32'd0);
        chk("sim_busy2", 32'(busy), 32'd0);

        // Reset after the second byte of a 4-byte message.
        reset = 1'b0; tick(); reset = 1'b1; tick();
        wr_bytes.delete();
        req0_valid = 1'b1; req0_data = 32'hA1B2C3D4; req0_len = 2'd3;
        tick();
        req0_valid = 1'b0;
        tick(); tick();
        chk("mid_b2", 32'(fifo_data), 32'hB2);
        reset = 1'b0; tick();
        chk("mid_en", 32'(fifo_en), 32'd0);
        chk("mid_data", 32'(fifo_data), 32'h00);
        chk("mid_credits", 32'(credits), 32'd8);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_grant", 32'(grant), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        chk("mid_count", 32'(wr_bytes.size()), 32'd2);
        chk("mid_ready", 32'(req0_ready), 32'd0);
        req0_valid = 1'b1; req0_data = 32'h33000000; req0_len = 2'd0;
        req1_valid = 1'b1; req1_data = 32'h44000000; req1_len = 2'd0;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("mid_tie_grant", 32'(grant), 32'd0);
        chk("mid_tie_ready", 32'({req0_ready, req1_ready}), 32'b10);
        tick();
        chk("mid_tie_data", 32'(fifo_data), 32'h33);

        // Spurious pop while credits are full.
        reset = 1'b0; tick(); reset = 1'b1;
        fifo_pop = 1'b1; tick(); fifo_pop = 1'b0;
        chk("ovf_set", 32'(overflow_err), 32'd1);
        chk("ovf_credits", 32'(credits), 32'd8);
        send_msg(1'b1, 32'h55000000, 2'd0);
        tick();
        chk("ovf_data", 32'(fifo_data), 32'h55);
        chk("ovf_credits2", 32'(credits), 32'd7);
        chk("ovf_sticky", 32'(overflow_err), 32'd1);
        fifo_pop = 1'b1; tick(); tick(); fifo_pop = 1'b0;
        chk("ovf_credits3", 32'(credits), 32'd8);
        chk("ovf_sticky2", 32'(overflow_err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
